// File: rtl/lc3_mem_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : lc3_mem_pkg
// Description : Shared types and defaults for the fetch/data memory scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Which requester owns the transfer in flight
    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Default number of memory access cycles per transfer
    localparam int WAIT_CYC_DEFAULT = 2;

endpackage : lc3_mem_pkg
`default_nettype wire

// File: rtl/mem_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_sched
// Description : Arbitrates instruction-fetch and data requests onto a single
//               shared memory port; one transfer at a time, fixed wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sched
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYC = WAIT_CYC_DEFAULT,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] C_CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_we;
    owner_t        r_owner;
    owner_t        r_last;
    logic          w_any_req;
    logic          w_grant_d;

    // Data wins unless fetch is waiting and data took the previous slot.
    assign w_any_req = f_req | d_req;
    assign w_grant_d = d_req & ~(f_req & (r_last == OWN_D));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> ACCESS (WAIT_CYC cycles) -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant latch, wait counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_owner <= OWN_F;
            r_last  <= OWN_F;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_cnt <= C_CNT_LOAD;
                        if (w_grant_d) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                            r_owner <= OWN_D;
                            r_last  <= OWN_D;
                        end else begin
                            r_addr  <= f_addr;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_owner <= OWN_F;
                            r_last  <= OWN_F;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        // Stores leave the read register untouched.
                        if (!r_we) r_rdata <= mem_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory strobes only during ACCESS; owner's ack only during DONE
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        f_ack     = 1'b0;
        d_ack     = 1'b0;
        case (r_state)
            ACCESS: begin
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                mem_rd    = ~r_we;
                mem_we    = r_we;
            end
            DONE: begin
                f_ack = (r_owner == OWN_F);
                d_ack = (r_owner == OWN_D);
            end
            default: ;
        endcase
    end

    assign f_rdata = r_rdata;
    assign d_rdata = r_rdata;
    assign busy    = (r_state != IDLE);

endmodule : mem_sched
`default_nettype wire
